router_path_streamer: RTL

//  Multi-channel successor to the single-request router front-end: NUM_CH requesters post
//  (src, dst, mode) route requests; a round-robin arbiter serves one at a time. For each

---
 rtl/router_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/router_path_streamer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the multi-channel mesh path streamer.
package router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_GEN,
      ST_SEND,
      ST_DONE
   } state_t;

   localparam logic MODE_XY   = 1'b0;
   localparam logic MODE_YX   = 1'b1;
   localparam logic SLOT_FILL = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
   import router_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]           req,
   input  logic [id_width(NUM_CH)-1:0] ptr,
   output logic [NUM_CH-1:0]           grant,
   output logic [id_width(NUM_CH)-1:0] idx,
   output logic                        any
);

   localparam int unsigned ID_W = id_width(NUM_CH);

   logic [2*NUM_CH-1:0] req_rot;
   logic                found;
   int unsigned         sel;

   assign req_rot = {req, req} >> ptr;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      sel   = 0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (!found && req_rot[k]) begin
            found = 1'b1;
            sel   = 32'(ptr) + k;
            if (sel >= NUM_CH) sel = sel - NUM_CH;
            idx   = ID_W'(sel);
            grant = NUM_CH'(1) << sel;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/router_path_streamer.sv
// Multi-channel mesh route walker: arbitrates requests, walks XY/YX paths and
// packs LANES coordinates per AXI-stream beat.
module router_path_streamer
   import router_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LANES  = 4,
   parameter int unsigned DATA_W = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            router_start_req,
   input  logic [NUM_CH*ADDR_W-1:0]     router_scr_addr,
   input  logic [NUM_CH*ADDR_W-1:0]     router_dst_addr,
   input  logic [NUM_CH-1:0]            router_mode,
   output logic [NUM_CH-1:0]            router_busy,
   output logic [NUM_CH-1:0]            router_done,
   output logic [DATA_W-1:0]            s_axis_tdata,
   output logic                         s_axis_tvalid,
   input  logic                         s_axis_tready,
   output logic                         s_axis_tlast,
   output logic [id_width(NUM_CH)-1:0]  s_axis_tid
);

   localparam int unsigned TID_W   = id_width(NUM_CH);
   localparam int unsigned HALF    = ADDR_W / 2;
   localparam int unsigned SLOT_W  = DATA_W / LANES;
   localparam int unsigned LANE_W  = id_width(LANES);
   localparam int unsigned MAX_LEN = 2 * ((32'd1 << HALF) - 1) + 1;
   localparam int unsigned HOP_W   = clog2(MAX_LEN + 1);

   state_t              state;
   logic [NUM_CH-1:0]   busy;
   logic [ADDR_W-1:0]   pend_src [NUM_CH];
   logic [ADDR_W-1:0]   pend_dst [NUM_CH];
   logic [NUM_CH-1:0]   pend_mode;
   logic [TID_W-1:0]    rr_ptr;
   logic [NUM_CH-1:0]   cur_oh;
   logic [ADDR_W-1:0]   cur;
   logic [ADDR_W-1:0]   dst_r;
   logic                mode_r;
   logic [LANE_W-1:0]   lane;
   logic [HOP_W-1:0]    hop;

   logic [NUM_CH-1:0]   cap;
   logic [NUM_CH-1:0]   clr;
   logic [NUM_CH-1:0]   arb_grant;
   logic [TID_W-1:0]    arb_idx;
   logic                arb_any;
   logic                accept;
   logic                at_dst;
   logic                path_end;
   logic                lane_full;
   logic [HALF-1:0]     nx, ny;
   logic [ADDR_W-1:0]   nxt_cur;

   assign router_busy = busy;
   assign accept      = (state == ST_SEND) && s_axis_tready;
   // A channel finishing this cycle still counts as busy for its own requests.
   assign cap = router_start_req & ~busy & ~({NUM_CH{state == ST_DONE}} & cur_oh);
   assign clr = {NUM_CH{accept && s_axis_tlast}} & cur_oh;

   assign at_dst    = (cur == dst_r);
   assign path_end  = at_dst || (hop == HOP_W'(MAX_LEN - 1));
   assign lane_full = (lane == LANE_W'(LANES - 1));

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req   (busy),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   function automatic logic [HALF-1:0] toward(input logic [HALF-1:0] a, input logic [HALF-1:0] b);
      return (a < b) ? a + HALF'(1) : a - HALF'(1);
   endfunction

   // One hop toward dst in the selected dimension order; holds once at dst.
   always_comb begin
      nx = cur[HALF-1:0];
      ny = cur[ADDR_W-1:HALF];
      case (mode_r)
         MODE_XY: begin
            if (cur[HALF-1:0] != dst_r[HALF-1:0])
               nx = toward(cur[HALF-1:0], dst_r[HALF-1:0]);
            else if (cur[ADDR_W-1:HALF] != dst_r[ADDR_W-1:HALF])
               ny = toward(cur[ADDR_W-1:HALF], dst_r[ADDR_W-1:HALF]);
         end
         MODE_YX: begin
            if (cur[ADDR_W-1:HALF] != dst_r[ADDR_W-1:HALF])
               ny = toward(cur[ADDR_W-1:HALF], dst_r[ADDR_W-1:HALF]);
            else if (cur[HALF-1:0] != dst_r[HALF-1:0])
               nx = toward(cur[HALF-1:0], dst_r[HALF-1:0]);
         end
      endcase
      nxt_cur = {ny, nx};
   end

   // Per-channel request capture and busy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= '0;
         pend_mode <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pend_src[i] <= '0;
            pend_dst[i] <= '0;
         end
      end else begin
         busy <= (busy | cap) & ~clr;
         for (int i = 0; i < NUM_CH; i++) begin
            if (cap[i]) begin
               pend_src[i]  <= router_scr_addr[i*ADDR_W +: ADDR_W];
               pend_dst[i]  <= router_dst_addr[i*ADDR_W +: ADDR_W];
               pend_mode[i] <= router_mode[i];
            end
         end
      end
   end

   // Service FSM with registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         rr_ptr        <= '0;
         cur_oh        <= '0;
         cur           <= '0;
         dst_r         <= '0;
         mode_r        <= MODE_XY;
         lane          <= '0;
         hop           <= '0;
         s_axis_tdata  <= '0;
         s_axis_tvalid <= 1'b0;
         s_axis_tlast  <= 1'b0;
         s_axis_tid    <= '0;
         router_done   <= '0;
      end else begin
         router_done <= '0;
         case (state)
            ST_IDLE: begin
               if ((|busy) || (|cap)) state <= ST_ARB;
            end
            ST_ARB: begin
               if (arb_any) begin
                  cur          <= pend_src[arb_idx];
                  dst_r        <= pend_dst[arb_idx];
                  mode_r       <= pend_mode[arb_idx];
                  cur_oh       <= arb_grant;
                  s_axis_tid   <= arb_idx;
                  rr_ptr       <= (arb_idx == TID_W'(NUM_CH - 1)) ? '0 : arb_idx + TID_W'(1);
                  lane         <= '0;
                  hop          <= '0;
                  s_axis_tdata <= {DATA_W{SLOT_FILL}};
                  state        <= ST_GEN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_GEN: begin
               s_axis_tdata[32'(lane)*SLOT_W +: SLOT_W] <= SLOT_W'(cur);
               cur <= nxt_cur;
               hop <= hop + HOP_W'(1);
               if (path_end || lane_full) begin
                  s_axis_tvalid <= 1'b1;
                  s_axis_tlast  <= path_end;
                  state         <= ST_SEND;
               end else begin
                  lane <= lane + LANE_W'(1);
               end
            end
            ST_SEND: begin
               if (s_axis_tready) begin
                  s_axis_tvalid <= 1'b0;
                  if (s_axis_tlast) begin
                     router_done <= cur_oh;
                     state       <= ST_DONE;
                  end else begin
                     lane         <= '0;
                     s_axis_tdata <= {DATA_W{SLOT_FILL}};
                     state        <= ST_GEN;
                  end
               end
            end
            ST_DONE: begin
               state <= ((|busy) || (|cap)) ? ST_ARB : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
